// File: rtl/aud_rmm_host_if.sv
// Host byte-stream and aud_rmm control signals of the aud_rmm_host sequencer.
// master is the sequencer side, slave is the host link / aud_rmm side.
interface aud_rmm_host_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rmm_addr;
    logic [1:0]  rmm_size;
    logic        rmm_we;
    logic        rmm_re;
    logic        rmm_err;
    logic        rmm_done;

    modport master (
        input  rx_data, rx_valid, tx_ready, rmm_err, rmm_done,
        output rx_ready, tx_data, tx_valid, rmm_addr, rmm_size, rmm_we, rmm_re
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, rmm_err, rmm_done,
        input  rx_ready, tx_data, tx_valid, rmm_addr, rmm_size, rmm_we, rmm_re
    );
endinterface

// File: rtl/aud_rmm_host.sv
// Host command sequencer: parses read/write packets from the host byte stream,
// issues one aud_rmm transaction per packet and returns status plus read data.
module aud_rmm_host #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic           aud_ck,
    input  logic           rst,
    aud_rmm_host_if.master bus,
    inout  wire  [31:0]    rmm_data,
    output logic           busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_WDATA, S_ISSUE, S_WAIT, S_STAT, S_RDATA
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  ST_OK    = 8'h00;
    localparam logic [7:0]  ST_ERR   = 8'h01;
    localparam logic [7:0]  ST_TMO   = 8'h02;
    localparam logic [7:0]  ST_ILL   = 8'h03;

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_cnt;
    logic        r_wr;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [7:0]  r_status;
    logic [15:0] r_tcnt;
    logic        w_op_ok;
    logic        w_resp;
    logic        w_tmo;
    logic        w_drive;

    assign w_op_ok = ((bus.rx_data[7:4] == 4'h1) || (bus.rx_data[7:4] == 4'h2)) &&
                     (bus.rx_data[3:2] == 2'b00) && (bus.rx_data[1:0] != 2'b11);
    assign w_resp  = bus.rmm_done | bus.rmm_err;
    assign w_tmo   = (r_tcnt == TMO_LAST);

    always_ff @(posedge aud_ck or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.rx_valid) w_next = w_op_ok ? S_ADDR : S_STAT;
            S_ADDR:  if (bus.rx_valid && r_cnt == 2'd3) w_next = r_wr ? S_WDATA : S_ISSUE;
            S_WDATA: if (bus.rx_valid && r_cnt == 2'd3) w_next = S_ISSUE;
            S_ISSUE: w_next = S_WAIT;
            S_WAIT:  if (w_resp || w_tmo) w_next = S_STAT;
            // Data bytes follow only a successful read.
            S_STAT:  if (bus.tx_ready) w_next = (r_status == ST_OK && !r_wr) ? S_RDATA : S_IDLE;
            S_RDATA: if (bus.tx_ready && r_cnt == 2'd3) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aud_ck or negedge rst) begin
        if (!rst) begin
            r_cnt  <= 2'd0;
            r_wr   <= 1'b0;
            r_size <= 2'd0;
            r_addr <= 32'd0;
            r_tcnt <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= 2'd0;
                    if (bus.rx_valid && w_op_ok) begin
                        r_wr   <= (bus.rx_data[7:4] == 4'h1);
                        r_size <= bus.rx_data[1:0];
                    end
                end
                S_ADDR: begin
                    if (bus.rx_valid) begin
                        r_cnt  <= r_cnt + 2'd1;
                        r_addr <= {r_addr[23:0], bus.rx_data};
                    end
                end
                S_WDATA: if (bus.rx_valid) r_cnt <= r_cnt + 2'd1;
                // r_tcnt equals the number of cycles elapsed since ISSUE.
                S_ISSUE: r_tcnt <= 16'd1;
                S_WAIT:  r_tcnt <= r_tcnt + 16'd1;
                S_STAT:  r_cnt <= 2'd0;
                S_RDATA: if (bus.tx_ready) r_cnt <= r_cnt + 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge aud_ck) begin
        if (r_state == S_WDATA && bus.rx_valid)
            r_wdata <= {r_wdata[23:0], bus.rx_data};
        if (r_state == S_WAIT && bus.rmm_done && !bus.rmm_err)
            r_rdata <= rmm_data;
        if (r_state == S_IDLE && bus.rx_valid && !w_op_ok) begin
            r_status <= ST_ILL;
        end else if (r_state == S_WAIT) begin
            if (bus.rmm_err)       r_status <= ST_ERR;
            else if (bus.rmm_done) r_status <= ST_OK;
            else if (w_tmo)        r_status <= ST_TMO;
        end
    end

    always_comb begin
        bus.rx_ready = 1'b0;
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'h00;
        bus.rmm_we   = 1'b0;
        bus.rmm_re   = 1'b0;
        w_drive      = 1'b0;
        busy         = (r_state != S_IDLE);
        case (r_state)
            S_IDLE, S_ADDR, S_WDATA: bus.rx_ready = 1'b1;
            S_ISSUE: begin
                bus.rmm_we = r_wr;
                bus.rmm_re = !r_wr;
                w_drive    = r_wr;
            end
            S_WAIT: w_drive = r_wr;
            S_STAT: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = r_status;
            end
            S_RDATA: begin
                bus.tx_valid = 1'b1;
                case (r_cnt)
                    2'd0:    bus.tx_data = r_rdata[31:24];
                    2'd1:    bus.tx_data = r_rdata[23:16];
                    2'd2:    bus.tx_data = r_rdata[15:8];
                    default: bus.tx_data = r_rdata[7:0];
                endcase
            end
            default: ;
        endcase
    end

    assign bus.rmm_addr = r_addr;
    assign bus.rmm_size = r_size;
    assign rmm_data     = w_drive ? r_wdata : 32'hZZZZ_ZZZZ;
endmodule

// File: tb/tb_aud_rmm_host.sv
// Bench for aud_rmm_host: acts as host link and aud_rmm stub, predicting every
// response byte from a packet-level model of the sequencer.
module tb_aud_rmm_host;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        busy;
    wire  [31:0] rmm_data;
    logic        stub_drv;
    logic [31:0] stub_val;
    int          n_total = 0;
    int          n_bad   = 0;

    aud_rmm_host_if bus_if ();

    assign rmm_data = stub_drv ? stub_val : 32'hzzzz_zzzz;

    aud_rmm_host #(.TIMEOUT(TMO)) dut (
        .aud_ck   (clk),
        .rst      (rst),
        .bus      (bus_if.master),
        .rmm_data (rmm_data),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_total++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    function automatic bit op_legal(input logic [7:0] op);
        return ((op[7:4] == 4'h1) || (op[7:4] == 4'h2)) && (op[3:2] == 2'b00) && (op[1:0] != 2'b11);
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_rx_ready"}, bus_if.rx_ready, 1);
        check_val({pfx, "_tx_valid"}, bus_if.tx_valid, 0);
        check_val({pfx, "_tx_data"},  bus_if.tx_data,  0);
        check_val({pfx, "_we"},       bus_if.rmm_we,   0);
        check_val({pfx, "_re"},       bus_if.rmm_re,   0);
        check_val({pfx, "_addr"},     bus_if.rmm_addr, 0);
        check_val({pfx, "_size"},     bus_if.rmm_size, 0);
        check_val({pfx, "_busy"},     busy,            0);
    endtask

    // resp_k: cycle after ISSUE at which the stub answers; mode 0=done 1=err 2=both
    // bp: 0 always ready, 1 random tx_ready, 2 five-cycle stall inside the response
    task automatic run_packet(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdat,
                              input int resp_k, input int mode, input logic [31:0] rdat,
                              input int bp, input bit gaps);
        logic [7:0] bytes[$];
        logic [7:0] exp_q[$];
        bit         legal;
        bit         is_wr;
        int         det;
        int         stat_k;
        int         idx;
        bit         stall_prev;
        bit         fin;
        logic [7:0] held;
        logic [7:0] st;

        legal = op_legal(op);
        is_wr = (op[7:4] == 4'h1);
        bytes.push_back(op);
        if (legal) begin
            for (int i = 3; i >= 0; i--) bytes.push_back(addr[8*i +: 8]);
            if (is_wr) for (int i = 3; i >= 0; i--) bytes.push_back(wdat[8*i +: 8]);
        end

        if (!legal) begin
            st = 8'h03; det = -1;
        end else if (resp_k >= 1 && resp_k <= TMO - 1) begin
            st = (mode == 0) ? 8'h00 : 8'h01; det = resp_k;
        end else begin
            st = 8'h02; det = TMO - 1;
        end
        stat_k = det + 1;
        exp_q.push_back(st);
        if (legal && !is_wr && st == 8'h00)
            for (int i = 3; i >= 0; i--) exp_q.push_back(rdat[8*i +: 8]);

        foreach (bytes[i]) begin
            if (gaps) repeat ($urandom_range(0, 1)) begin
                @(posedge clk); #1;
                bus_if.rx_valid = 1'b0;
            end
            @(posedge clk); #1;
            bus_if.rx_valid = 1'b1;
            bus_if.rx_data  = bytes[i];
            @(negedge clk);
            check_val("rx_ready", bus_if.rx_ready, 1);
        end
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;

        idx = 0; stall_prev = 1'b0; fin = 1'b0; held = 8'h00;
        for (int k = 0; k < 300 && !fin; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
            end
            bus_if.rmm_done = legal && (k == resp_k) && (mode != 1);
            bus_if.rmm_err  = legal && (k == resp_k) && (mode != 0);
            stub_drv        = legal && !is_wr && (k == resp_k) && (mode == 0);
            stub_val        = rdat;
            case (bp)
                0:       bus_if.tx_ready = 1'b1;
                1:       bus_if.tx_ready = ($urandom_range(0, 2) != 0);
                default: bus_if.tx_ready = !(k >= stat_k + 2 && k < stat_k + 7);
            endcase
            @(negedge clk);
            if (legal && k == 0) begin
                check_val("issue_we",   bus_if.rmm_we,   is_wr);
                check_val("issue_re",   bus_if.rmm_re,   !is_wr);
                check_val("issue_addr", bus_if.rmm_addr, addr);
                check_val("issue_size", bus_if.rmm_size, op[1:0]);
                check_val("issue_busy", busy, 1);
                if (is_wr) check_val("issue_wdata", rmm_data, wdat);
            end
            if (legal && k == 1) check_val("pulse_end", {bus_if.rmm_we, bus_if.rmm_re}, 0);
            if (legal && k == det) begin
                check_val("addr_hold", bus_if.rmm_addr, addr);
                check_val("size_hold", bus_if.rmm_size, op[1:0]);
                if (is_wr) check_val("wdata_last", rmm_data, wdat);
            end
            if (k < stat_k) begin
                check_val("tx_early", bus_if.tx_valid, 0);
            end else begin
                if (k == stat_k) check_val("stat_lat", bus_if.tx_valid, 1);
                if (stall_prev && bus_if.tx_valid) check_val("tx_hold", bus_if.tx_data, held);
                if (bus_if.tx_valid && bus_if.tx_ready) begin
                    check_val($sformatf("tx_byte%0d", idx), bus_if.tx_data, exp_q[idx]);
                    idx++;
                    stall_prev = 1'b0;
                    if (idx == exp_q.size()) fin = 1'b1;
                end else if (bus_if.tx_valid) begin
                    stall_prev = 1'b1;
                    held       = bus_if.tx_data;
                end else begin
                    stall_prev = 1'b0;
                end
            end
        end
        check_val("nbytes", idx, exp_q.size());

        @(posedge clk); #1;
        bus_if.rmm_done = 1'b0;
        bus_if.rmm_err  = 1'b0;
        stub_drv        = 1'b0;
        bus_if.tx_ready = 1'b1;
        @(negedge clk);
        check_val("end_busy",  busy, 0);
        check_val("end_txv",   bus_if.tx_valid, 0);
    endtask

    task automatic reset_mid_wdata();
        logic [7:0] b[7] = '{8'h12, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h55, 8'h66};
        foreach (b[i]) begin
            @(posedge clk); #1;
            bus_if.rx_valid = 1'b1;
            bus_if.rx_data  = b[i];
        end
        @(posedge clk); #1;
        bus_if.rx_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        logic [7:0] op;
        rst             = 1'b0;
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'h00;
        bus_if.tx_ready = 1'b1;
        bus_if.rmm_done = 1'b0;
        bus_if.rmm_err  = 1'b0;
        stub_drv        = 1'b0;
        stub_val        = 32'h0;
        @(negedge clk);
        check_reset_vals("por");
        @(posedge clk); #1;
        rst = 1'b1;

        run_packet(8'h12, 32'h0123_4567, 32'h89AB_CDEF, 10,  0, 32'h0,         0, 1'b0);
        run_packet(8'h12, 32'h0123_4567, 32'h89AB_CDEF, 20,  0, 32'h0,         0, 1'b0);
        run_packet(8'h22, 32'h0123_4567, 32'h0,         5,   0, 32'h0123_4567, 0, 1'b0);
        run_packet(8'h22, 32'h0123_4567, 32'h0,         3,   1, 32'h0123_4567, 0, 1'b0);
        run_packet(8'h22, 32'h0123_4567, 32'h0,         3,   2, 32'h0123_4567, 0, 1'b0);
        run_packet(8'h20, 32'hA5A5_0000, 32'h0,         TMO, 0, 32'h0000_0001, 0, 1'b0);
        run_packet(8'h33, 32'h0,         32'h0,         1,   0, 32'h0,         0, 1'b0);
        run_packet(8'h21, 32'h0000_0010, 32'h0,         4,   0, 32'hCAFE_F00D, 0, 1'b0);
        run_packet(8'h22, 32'h0000_0040, 32'h0,         2,   0, 32'h1122_3344, 2, 1'b0);
        reset_mid_wdata();
        run_packet(8'h11, 32'h00FF_00FF, 32'h1234_5678, 6,   0, 32'h0,         1, 1'b1);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 7)
                op = {($urandom_range(0, 1) != 0) ? 4'h1 : 4'h2, 2'b00, 2'($urandom_range(0, 2))};
            else
                op = 8'($urandom);
            run_packet(op, $urandom, $urandom, $urandom_range(1, TMO + 4), $urandom_range(0, 2),
                       $urandom, $urandom_range(0, 2), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
